// File: rtl/c3lib_rst_seq_ctrl.sv
// c3lib_rst_seq_ctrl: reset-release sequencer for c3lib hardened-primitive domains.
// Synchronizes deassertion of the chip-level async reset. It then releases
// NUM_STAGES active-low domain resets in index order. Each stage waits for its
// own programmable delay before it is released. Software can force a full
// re-reset through sw_rst_req_i.
// Optional feature macro: C3LIB_RST_SEQ_ACK_EN. When defined, each release
// waits for a synchronized per-stage acknowledge before the sequencer moves on.
module c3lib_rst_seq_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  localparam int STG_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sw_rst_req_i,
  input  logic [NUM_STAGES*CNT_W-1:0] stage_dly_i,
`ifdef C3LIB_RST_SEQ_ACK_EN
  input  logic [NUM_STAGES-1:0]       stage_ack_i,
`endif
  output logic [NUM_STAGES-1:0]       rst_n_out_o,
  output logic                        seq_done_o,
  output logic [STG_W-1:0]            seq_stage_o
);

  localparam logic [2:0] ST_HOLD     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_COUNT    = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
`ifdef C3LIB_RST_SEQ_ACK_EN
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rel;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STG_W-1:0]       stage_q, stage_d;
  logic [NUM_STAGES-1:0]  rstn_q, rstn_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       load_val;
  logic [CNT_W-1:0]       dly_fld [NUM_STAGES];

  // Deassertion synchronizer: flops clear asynchronously and shift in ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_rel = sync_q[SYNC_STAGES-1];

  // Split the flat delay bus into one field per stage
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_dly
    assign dly_fld[gi] = stage_dly_i[gi*CNT_W +: CNT_W];
  end

  // Select the delay field of the stage currently being sequenced
  always_comb begin
    load_val = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == STG_W'(i)) load_val = dly_fld[i];
    end
  end

`ifdef C3LIB_RST_SEQ_ACK_EN
  logic [NUM_STAGES-1:0] ack_meta_q, ack_sync_q;
  logic                  ack_cur;

  // Two-flop synchronizer for the per-stage acknowledges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= '0;
      ack_sync_q <= '0;
    end else begin
      ack_meta_q <= stage_ack_i;
      ack_sync_q <= ack_meta_q;
    end
  end

  // Acknowledge of the stage most recently released (index stage_q-1)
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == STG_W'(i + 1)) ack_cur = ack_sync_q[i];
    end
  end
`endif

  // Sequencer next-state logic; a software request outranks every other transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rstn_d  = rstn_q;
    done_d  = 1'b0;
    if (sw_rst_req_i && (state_q != ST_HOLD)) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      stage_d = '0;
      rstn_d  = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (sync_rel && !sw_rst_req_i) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          cnt_d   = load_val;
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (cnt_q == '0) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (stage_q == STG_W'(i)) rstn_d[i] = 1'b1;
            end
            stage_d = stage_q + STG_W'(1);
`ifdef C3LIB_RST_SEQ_ACK_EN
            state_d = ST_WAIT_ACK;
`else
            state_d = (stage_q == STG_W'(NUM_STAGES - 1)) ? ST_DONE : ST_LOAD;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`ifdef C3LIB_RST_SEQ_ACK_EN
        ST_WAIT_ACK: begin
          if (ack_cur) state_d = (stage_q == STG_W'(NUM_STAGES)) ? ST_DONE : ST_LOAD;
        end
`endif
        ST_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          stage_d = '0;
          rstn_d  = '0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
    end
  end

  assign rst_n_out_o = rstn_q;
  assign seq_done_o  = done_q;
  assign seq_stage_o = stage_q;

endmodule

// File: doc/c3lib_rst_seq_ctrl.md
Name: c3lib_rst_seq_ctrl

Overview:
- Reset-release sequencer for c3lib hardened-primitive domains (flop banks using async-reset/async-set DFF cells).
- Synchronizes deassertion of the chip-level asynchronous reset.
- Releases NUM_STAGES downstream active-low resets in fixed index order, with a programmable per-stage delay.
- Supports software-initiated re-reset; signals sequence completion.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs (1..16).
- CNT_W, 8, width of each per-stage delay field and of the delay counter.
- SYNC_STAGES, 2, flop depth of the rst_n deassertion synchronizer (>=2).

Ports:
- clk  input  1  sequencer clock.
- rst_n  input  1  asynchronous active-low reset. Assertion is async; deassertion is synchronized internally.
- sw_rst_req  input  1  synchronous level request; high forces all stage resets asserted.
- stage_dly  input  NUM_STAGES*CNT_W  static delay config; field i = bits [i*CNT_W +: CNT_W].
- rst_n_out  output  NUM_STAGES  sequenced active-low resets; bit i feeds domain i.
- seq_done  output  1  high when all stages are released and the sequence is stable.
- seq_stage  output  $clog2(NUM_STAGES+1)  index of the next stage to release; NUM_STAGES when done.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - rst_n_out = 0, seq_done = 0, seq_stage = 0, counter = 0, FSM = HOLD.
  - Synchronizer flops cleared.
- Synchronizer: SYNC_STAGES flops reset to 0 that shift in 1. sync_rel goes high on the SYNC_STAGES-th clk rise after rst_n deasserts.
- FSM states:
  - HOLD: all outputs asserted (0). Exit to LOAD when sync_rel=1 and sw_rst_req=0.
  - LOAD: counter <= stage_dly[seq_stage]; go to COUNT.
  - COUNT: if counter==0, then rst_n_out[seq_stage] <= 1 and seq_stage++. Next state is LOAD if stages remain, else DONE. Otherwise counter--.
  - DONE: seq_done=1; hold until sw_rst_req.
- Timing rule: stage i releases exactly stage_dly[i]+2 cycles after the previous event. The previous event is stage i-1 release, or FSM leaving HOLD for stage 0. seq_done rises 1 cycle after the last release.
- Released stages stay released; rst_n_out bits are monotonic within a sequence.
- sw_rst_req=1 in any non-HOLD state: on the next clk rise, rst_n_out=0, seq_done=0, seq_stage=0, FSM=HOLD. Stays in HOLD while the request is high. Restarts the full sequence from stage 0 the cycle after the request drops.
- stage_dly is sampled only in LOAD; changes mid-count take effect at the next stage.
- rst_n glitch low mid-sequence: immediate async return to the reset state, then full resynchronization.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: C3LIB_RST_SEQ_ACK_EN.
- Defined:
  - Adds input stage_ack [NUM_STAGES]. Each bit is synchronized by a 2-flop synchronizer reset to 0.
  - Adds state WAIT_ACK after each release. The FSM stays in WAIT_ACK until synced stage_ack[i-1]=1, then proceeds to LOAD, or to DONE after the last stage.
  - This adds 1 + ack latency cycles per stage.
  - sw_rst_req aborts WAIT_ACK as in any other non-HOLD state.
- Undefined: the port and state are absent; timing is as in Behaviour.

Test Plan (NUM_STAGES=4, SYNC_STAGES=2, CNT_W=8, stage_dly={1,5,0,3} for stages 3..0):
- Reset release: rst_n rises before edge E1.
  - sync_rel=1 at E2; HOLD exits at E3.
  - rst_n_out bit0 at E8, bit1 at E10, bit2 at E17, bit3 at E20.
  - seq_done at E21.
  - Intermediate rst_n_out values: 4'b0001, 4'b0011, 4'b0111, 4'b1111.
- Async reset mid-sequence: rst_n low between E12 and E13 -> rst_n_out=0, seq_done=0 without a clk edge. After release, the full sequence repeats with identical relative timing.
- sw_rst_req pulse in DONE, high for 3 cycles -> rst_n_out=0 one edge after the first high sample. The sequence restarts the cycle after the request drops; bit0 releases 5 edges after HOLD exit.
- sw_rst_req high mid-count at stage 2 -> stages 0 and 1 re-assert on the next edge; seq_stage=0.
- All delays = 0 -> releases on 4 consecutive alternate edges (2 cycles apart); seq_done 1 edge after the last release.
- With C3LIB_RST_SEQ_ACK_EN: hold stage_ack[0]=0 for 10 cycles after bit0 releases -> bit1 stays 0. Raise the ack -> bit1 releases 2 (sync) + 1 (WAIT_ACK) + 2 (dly 0 count) edges later.
